// File: rtl/prim_generic_fork2.sv
// Valid/ready stream fork: one input stream broadcast to two independent
// branches. A beat retires once both branches have taken it; a 2-entry
// buffer keeps in_ready_o free of any combinational path from the branches.
module prim_generic_fork2 #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out0_valid_o,
    input  logic             out0_ready_i,
    output logic [Width-1:0] out0_data_o,
    output logic             out1_valid_o,
    input  logic             out1_ready_i,
    output logic [Width-1:0] out1_data_o,
    output logic [1:0]       count_o
);

    localparam int unsigned Depth  = 2;
    localparam int unsigned CountW = 2;

    logic [Width-1:0]  mem [Depth];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [CountW-1:0] count;
    logic              done0;
    logic              done1;

    logic              push;
    logic              retire;
    logic              acc0;
    logic              acc1;
    logic              not_empty;

    // Handshake decode: ready depends on registered count only
    always_comb begin
        not_empty    = (count != CountW'(0));
        in_ready_o   = (count != CountW'(Depth));
        push         = in_valid_i & in_ready_o & ~flush_i;
        out0_valid_o = not_empty & ~done0 & ~flush_i;
        out1_valid_o = not_empty & ~done1 & ~flush_i;
        acc0         = out0_valid_o & out0_ready_i;
        acc1         = out1_valid_o & out1_ready_i;
        retire       = (done0 | acc0) & (done1 | acc1) & not_empty;
        out0_data_o  = mem[rd_ptr];
        out1_data_o  = mem[rd_ptr];
        count_o      = count;
    end

    // Payload storage, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    // Pointers, occupancy and per-branch accepted flags for the head beat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= CountW'(0);
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= CountW'(0);
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            count <= count + CountW'(push) - CountW'(retire);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (retire) begin
                rd_ptr <= ~rd_ptr;
                done0  <= 1'b0;
                done1  <= 1'b0;
            end else begin
                done0  <= done0 | acc0;
                done1  <= done1 | acc1;
            end
        end
    end

    // Occupancy bound
    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        count <= CountW'(Depth));

    // A stalled branch sees a stable payload
    a_stable0: assert property (@(posedge clk_i) disable iff (rst_i)
        (out0_valid_o && !out0_ready_i && !flush_i) |=> $stable(out0_data_o));

    a_stable1: assert property (@(posedge clk_i) disable iff (rst_i)
        (out1_valid_o && !out1_ready_i && !flush_i) |=> $stable(out1_data_o));

    // Accepted flags only exist while a head beat exists
    a_done_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
        (done0 || done1) |-> not_empty);

    // Never retire from an empty buffer
    a_retire_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
        retire |-> not_empty);

endmodule

// File: tb/tb_prim_generic_fork2.sv
// Bench for prim_generic_fork2: queue-level reference model with a per-cycle
// compare, plus directed scenarios with hand-computed expectations.
module tb_prim_generic_fork2;

    localparam int unsigned W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic         out0_valid_o;
    logic         out0_ready_i;
    logic [W-1:0] out0_data_o;
    logic         out1_valid_o;
    logic         out1_ready_i;
    logic [W-1:0] out1_data_o;
    logic [1:0]   count_o;

    int errors = 0;
    int checks = 0;

    prim_generic_fork2 #(.Width(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .out0_valid_o (out0_valid_o),
        .out0_ready_i (out0_ready_i),
        .out0_data_o  (out0_data_o),
        .out1_valid_o (out1_valid_o),
        .out1_ready_i (out1_ready_i),
        .out1_data_o  (out1_data_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of beats plus "branch already took the head" flags
    logic [W-1:0] mq[$];
    bit           t0, t1;
    bit           m_ne, m_a0, m_a1, m_can_push;
    logic [W-1:0] got0[$];
    logic [W-1:0] got1[$];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            mq.delete();
            t0 = 1'b0;
            t1 = 1'b0;
        end else begin
            m_can_push = (mq.size() < 2);
            m_ne       = (mq.size() != 0);
            m_a0       = m_ne && !t0 && out0_ready_i;
            m_a1       = m_ne && !t1 && out1_ready_i;
            if (m_ne && (t0 || m_a0) && (t1 || m_a1)) begin
                void'(mq.pop_front());
                t0 = 1'b0;
                t1 = 1'b0;
            end else begin
                t0 = t0 | m_a0;
                t1 = t1 | m_a1;
            end
            if (m_can_push && in_valid_i) mq.push_back(in_data_i);
        end
    end

    // Per-cycle compare of DUT outputs against the model; also logs accepts
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("m_in_ready", W'(in_ready_o), W'(mq.size() < 2));
            chk("m_count", W'(count_o), W'(mq.size()));
            chk("m_v0", W'(out0_valid_o), W'(mq.size() != 0 && !t0 && !flush_i));
            chk("m_v1", W'(out1_valid_o), W'(mq.size() != 0 && !t1 && !flush_i));
            if (mq.size() != 0 && !t0 && !flush_i) chk("m_d0", out0_data_o, mq[0]);
            if (mq.size() != 0 && !t1 && !flush_i) chk("m_d1", out1_data_o, mq[0]);
            if (out0_valid_o && out0_ready_i) got0.push_back(out0_data_o);
            if (out1_valid_o && out1_ready_i) got1.push_back(out1_data_o);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    // Hand-computed output expectation; data checked only where a branch is valid
    task automatic expect_out(input string tag, input logic rdy, input logic v0,
                              input logic v1, input logic [W-1:0] d, input logic [1:0] cnt);
        chk({tag, "_rdy"}, W'(in_ready_o), W'(rdy));
        chk({tag, "_v0"}, W'(out0_valid_o), W'(v0));
        chk({tag, "_v1"}, W'(out1_valid_o), W'(v1));
        chk({tag, "_cnt"}, W'(count_o), W'(cnt));
        if (v0) chk({tag, "_d0"}, out0_data_o, d);
        if (v1) chk({tag, "_d1"}, out1_data_o, d);
    endtask

    int n;

    initial begin
        rst_i        = 1'b1;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        in_data_i    = '0;
        out0_ready_i = 1'b0;
        out1_ready_i = 1'b0;
        #1;
        expect_out("reset", 1'b1, 1'b0, 1'b0, '0, 2'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Streaming with both branches ready
        out0_ready_i = 1'b1; out1_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 32'h11;
        at_neg(); expect_out("st0", 1'b1, 1'b0, 1'b0, '0, 2'd0);
        cyc(); in_data_i = 32'h22;
        at_neg(); expect_out("st1", 1'b1, 1'b1, 1'b1, 32'h11, 2'd1);
        cyc(); in_data_i = 32'h33;
        at_neg(); expect_out("st2", 1'b1, 1'b1, 1'b1, 32'h22, 2'd1);
        cyc(); in_valid_i = 1'b0;
        at_neg(); expect_out("st3", 1'b1, 1'b1, 1'b1, 32'h33, 2'd1);
        cyc();
        at_neg(); expect_out("st4", 1'b1, 1'b0, 1'b0, '0, 2'd0);

        // Skewed accept: branch 0 takes the beat, branch 1 later
        cyc(); out1_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA5;
        at_neg(); expect_out("sk0", 1'b1, 1'b0, 1'b0, '0, 2'd0);
        cyc(); in_valid_i = 1'b0;
        at_neg(); expect_out("sk1", 1'b1, 1'b1, 1'b1, 32'hA5, 2'd1);
        cyc();
        at_neg(); expect_out("sk2", 1'b1, 1'b0, 1'b1, 32'hA5, 2'd1);
        cyc();
        at_neg(); expect_out("sk3", 1'b1, 1'b0, 1'b1, 32'hA5, 2'd1);
        cyc(); out1_ready_i = 1'b1;
        at_neg(); expect_out("sk4", 1'b1, 1'b0, 1'b1, 32'hA5, 2'd1);
        cyc();
        at_neg(); expect_out("sk5", 1'b1, 1'b0, 1'b0, '0, 2'd0);

        // Backpressure to full, third beat held off until a retire
        cyc(); out0_ready_i = 1'b0; out1_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h1;
        at_neg(); expect_out("bp0", 1'b1, 1'b0, 1'b0, '0, 2'd0);
        cyc(); in_data_i = 32'h2;
        at_neg(); expect_out("bp1", 1'b1, 1'b1, 1'b1, 32'h1, 2'd1);
        cyc(); in_data_i = 32'h3;
        at_neg(); expect_out("bp2", 1'b0, 1'b1, 1'b1, 32'h1, 2'd2);
        cyc(); out0_ready_i = 1'b1; out1_ready_i = 1'b1;
        at_neg(); expect_out("bp3", 1'b0, 1'b1, 1'b1, 32'h1, 2'd2);
        cyc();
        at_neg(); expect_out("bp4", 1'b1, 1'b1, 1'b1, 32'h2, 2'd1);
        cyc(); in_valid_i = 1'b0;
        at_neg(); expect_out("bp5", 1'b1, 1'b1, 1'b1, 32'h3, 2'd1);
        cyc();
        at_neg(); expect_out("bp6", 1'b1, 1'b0, 1'b0, '0, 2'd0);

        // 16 beats with random readies across pointer wrap
        got0.delete();
        got1.delete();
        n = 0;
        for (int k = 0; k < 400 && !(n == 16 && count_o == 2'd0); k++) begin
            cyc();
            in_valid_i   = (n < 16);
            in_data_i    = 32'h100 + W'(n);
            out0_ready_i = (n < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
            out1_ready_i = (n < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
            at_neg();
            if (in_valid_i && in_ready_o) n++;
        end
        in_valid_i = 1'b0;
        chk("rnd_pushed", W'(n), W'(16));
        chk("rnd_drained", W'(count_o), W'(0));
        chk("rnd_n0", W'(got0.size()), W'(16));
        chk("rnd_n1", W'(got1.size()), W'(16));
        for (int i = 0; i < 16; i++) begin
            if (i < got0.size()) chk("rnd_seq0", got0[i], 32'h100 + W'(i));
            if (i < got1.size()) chk("rnd_seq1", got1[i], 32'h100 + W'(i));
        end

        // Flush while the head is half-accepted; pushed beat in flush cycle is lost
        cyc(); out0_ready_i = 1'b1; out1_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h5A;
        at_neg(); expect_out("fl0", 1'b1, 1'b0, 1'b0, '0, 2'd0);
        cyc(); in_valid_i = 1'b0;
        at_neg(); expect_out("fl1", 1'b1, 1'b1, 1'b1, 32'h5A, 2'd1);
        cyc(); flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hEE;
        at_neg(); expect_out("fl2", 1'b1, 1'b0, 1'b0, '0, 2'd1);
        cyc(); flush_i = 1'b0; in_data_i = 32'h77; out1_ready_i = 1'b1;
        at_neg(); expect_out("fl3", 1'b1, 1'b0, 1'b0, '0, 2'd0);
        cyc(); in_valid_i = 1'b0;
        at_neg(); expect_out("fl4", 1'b1, 1'b1, 1'b1, 32'h77, 2'd1);
        cyc();
        at_neg(); expect_out("fl5", 1'b1, 1'b0, 1'b0, '0, 2'd0);

        // Asynchronous reset between clock edges while full
        cyc(); out0_ready_i = 1'b0; out1_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h1;
        at_neg();
        cyc(); in_data_i = 32'h2;
        at_neg();
        cyc(); in_valid_i = 1'b0;
        at_neg(); expect_out("ar0", 1'b0, 1'b1, 1'b1, 32'h1, 2'd2);
        #2 rst_i = 1'b1;
        #1 expect_out("ar1", 1'b1, 1'b0, 1'b0, '0, 2'd0);
        cyc();
        cyc(); rst_i = 1'b0;
        at_neg(); expect_out("ar2", 1'b1, 1'b0, 1'b0, '0, 2'd0);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
